// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register address width,
// FSM state codes and the register-match helper.
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_BR_FLUSH = 2'd2
  } hz_state_t;

  // R0 is hardwired zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dest);
    return (dest != '0) && (src == dest);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline status in, register controls and statistics out.
// master = datapath side, slave = hazard controller.
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic                  fwd_en;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_two_src;
  logic [REG_ADDR_W-1:0] exe_dest;
  logic                  exe_wb_en;
  logic                  exe_mem_r_en;
  logic                  exe_br_taken;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_wb_en;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  pc_freeze;
  logic                  if_id_freeze;
  logic                  id_exe_freeze;
  logic                  exe_mem_freeze;
  logic                  if_id_flush;
  logic                  id_exe_bubble;
  logic                  mem_wb_bubble;
  logic                  mem_err;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output fwd_en, id_valid, id_src1, id_src2, id_two_src,
           exe_dest, exe_wb_en, exe_mem_r_en, exe_br_taken,
           mem_dest, mem_wb_en, mem_req, mem_ready,
    input  pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze,
           if_id_flush, id_exe_bubble, mem_wb_bubble,
           mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  fwd_en, id_valid, id_src1, id_src2, id_two_src,
           exe_dest, exe_wb_en, exe_mem_r_en, exe_br_taken,
           mem_dest, mem_wb_en, mem_req, mem_ready,
    output pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze,
           if_id_flush, id_exe_bubble, mem_wb_bubble,
           mem_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational compare of the ID sources against one in-flight destination.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic                  dest_wr,
  output logic                  hit
);

  assign hit = id_valid & dest_wr &
               (reg_match(id_src1, dest) | (id_two_src & reg_match(id_src2, dest)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, taken-branch flushes and memory-wait
// freezes for the PC/IF/ID/EXE/MEM/WB registers, plus stall/flush statistics.
//
//   state       | meaning
//   HZ_RUN      | normal issue; hazards and branches resolved combinationally
//   HZ_MEM_WAIT | data memory busy; pipe frozen until ready or timeout
//   HZ_BR_FLUSH | extra post-branch flush cycles still owed (fl_cnt)
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int BR_FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 255,
  parameter int CNT_W           = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);

  // wait_cnt counts stalled cycles already spent; the cycle that would be the
  // MEM_TIMEOUT-th is the one that is forcibly released.
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);
  localparam logic [2:0] FL_INIT    = 3'(BR_FLUSH_CYCLES - 1);

  hz_state_t        state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [2:0]       fl_cnt_q, fl_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic hit_exe, hit_mem, load_use;
  logic timeout_now, mem_stall, br_take;
  logic pc_frz, ifid_frz, idexe_frz, exemem_frz, ifid_fl, idexe_bub, memwb_bub;

  // With forwarding only a load in EXE must stall; without it any writer in EXE or MEM does.
  pipe_hazard_ctrl_hazard_detect u_hd_exe (
    .id_valid   (hz.id_valid),
    .id_src1    (hz.id_src1),
    .id_src2    (hz.id_src2),
    .id_two_src (hz.id_two_src),
    .dest       (hz.exe_dest),
    .dest_wr    (hz.exe_wb_en & (~hz.fwd_en | hz.exe_mem_r_en)),
    .hit        (hit_exe)
  );

  pipe_hazard_ctrl_hazard_detect u_hd_mem (
    .id_valid   (hz.id_valid),
    .id_src1    (hz.id_src1),
    .id_src2    (hz.id_src2),
    .id_two_src (hz.id_two_src),
    .dest       (hz.mem_dest),
    .dest_wr    (hz.mem_wb_en & ~hz.fwd_en),
    .hit        (hit_mem)
  );

  assign load_use    = hit_exe | hit_mem;
  assign timeout_now = (state_q == HZ_MEM_WAIT) && (wait_cnt_q == WAIT_LIMIT);
  assign mem_stall   = hz.mem_req & ~hz.mem_ready & ~timeout_now;
  assign br_take     = (state_q == HZ_RUN) & hz.exe_br_taken & ~mem_stall;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    fl_cnt_d   = fl_cnt_q;
    mem_err_d  = mem_err_q;
    pc_frz     = 1'b0;
    ifid_frz   = 1'b0;
    idexe_frz  = 1'b0;
    exemem_frz = 1'b0;
    ifid_fl    = 1'b0;
    idexe_bub  = 1'b0;
    memwb_bub  = 1'b0;

    if (mem_stall) begin
      pc_frz     = 1'b1;
      ifid_frz   = 1'b1;
      idexe_frz  = 1'b1;
      exemem_frz = 1'b1;
      memwb_bub  = 1'b1;
    end else if ((state_q == HZ_BR_FLUSH) || br_take) begin
      ifid_fl   = 1'b1;
      idexe_bub = 1'b1;
    end else if (load_use) begin
      pc_frz    = 1'b1;
      ifid_frz  = 1'b1;
      idexe_bub = 1'b1;
    end

    unique case (state_q)
      HZ_RUN: begin
        if (mem_stall) begin
          state_d    = HZ_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else if (br_take && (BR_FLUSH_CYCLES > 1)) begin
          state_d  = HZ_BR_FLUSH;
          fl_cnt_d = FL_INIT;
        end
      end
      HZ_MEM_WAIT: begin
        if (mem_stall) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          wait_cnt_d = 8'd0;
          if (timeout_now && hz.mem_req && !hz.mem_ready) mem_err_d = 1'b1;
          state_d = (fl_cnt_q != 3'd0) ? HZ_BR_FLUSH : HZ_RUN;
        end
      end
      HZ_BR_FLUSH: begin
        if (mem_stall) begin
          state_d    = HZ_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          fl_cnt_d = fl_cnt_q - 3'd1;
          if (fl_cnt_q == 3'd1) state_d = HZ_RUN;
        end
      end
      default: state_d = HZ_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= HZ_RUN;
      wait_cnt_q  <= 8'd0;
      fl_cnt_q    <= 3'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
      mem_err_q  <= mem_err_d;
      if (pc_frz && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (br_take && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Controls are gated by the async reset so they drop the instant it asserts.
  assign hz.pc_freeze      = rst & pc_frz;
  assign hz.if_id_freeze   = rst & ifid_frz;
  assign hz.id_exe_freeze  = rst & idexe_frz;
  assign hz.exe_mem_freeze = rst & exemem_frz;
  assign hz.if_id_flush    = rst & ifid_fl;
  assign hz.id_exe_bubble  = rst & idexe_bub;
  assign hz.mem_wb_bubble  = rst & memwb_bub;
  assign hz.mem_err        = mem_err_q;
  assign hz.stall_cnt      = stall_cnt_q;
  assign hz.flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one default instance and one with
// BR_FLUSH_CYCLES=3 / MEM_TIMEOUT=3, both driven by the same stimulus.
module tb_pipe_hazard_ctrl;

  // control vector: {pc_frz, ifid_frz, idexe_frz, exemem_frz, ifid_fl, idexe_bub, memwb_bub}
  localparam int C_NONE = 'h00;
  localparam int C_LU   = 'h62;
  localparam int C_MS   = 'h79;
  localparam int C_BR   = 'h06;

  logic       clk;
  logic       rst;
  logic       fwd_en, id_valid, id_two_src, exe_wb_en, exe_mem_r_en, exe_br_taken;
  logic       mem_wb_en, mem_req, mem_ready;
  logic [4:0] id_src1, id_src2, exe_dest, mem_dest;

  int n_chk;
  int n_err;

  pipe_hazard_ctrl_if #(.CNT_W(16)) if_d ();
  pipe_hazard_ctrl_if #(.CNT_W(16)) if_t ();

  assign if_d.fwd_en = fwd_en;          assign if_t.fwd_en = fwd_en;
  assign if_d.id_valid = id_valid;      assign if_t.id_valid = id_valid;
  assign if_d.id_src1 = id_src1;        assign if_t.id_src1 = id_src1;
  assign if_d.id_src2 = id_src2;        assign if_t.id_src2 = id_src2;
  assign if_d.id_two_src = id_two_src;  assign if_t.id_two_src = id_two_src;
  assign if_d.exe_dest = exe_dest;      assign if_t.exe_dest = exe_dest;
  assign if_d.exe_wb_en = exe_wb_en;    assign if_t.exe_wb_en = exe_wb_en;
  assign if_d.exe_mem_r_en = exe_mem_r_en; assign if_t.exe_mem_r_en = exe_mem_r_en;
  assign if_d.exe_br_taken = exe_br_taken; assign if_t.exe_br_taken = exe_br_taken;
  assign if_d.mem_dest = mem_dest;      assign if_t.mem_dest = mem_dest;
  assign if_d.mem_wb_en = mem_wb_en;    assign if_t.mem_wb_en = mem_wb_en;
  assign if_d.mem_req = mem_req;        assign if_t.mem_req = mem_req;
  assign if_d.mem_ready = mem_ready;    assign if_t.mem_ready = mem_ready;

  pipe_hazard_ctrl #(.BR_FLUSH_CYCLES(1), .MEM_TIMEOUT(255), .CNT_W(16)) dut_d (
    .clk (clk), .rst (rst), .hz (if_d)
  );

  pipe_hazard_ctrl #(.BR_FLUSH_CYCLES(3), .MEM_TIMEOUT(3), .CNT_W(16)) dut_t (
    .clk (clk), .rst (rst), .hz (if_t)
  );

  logic [6:0] ctl_d, ctl_t;
  assign ctl_d = {if_d.pc_freeze, if_d.if_id_freeze, if_d.id_exe_freeze, if_d.exe_mem_freeze,
                  if_d.if_id_flush, if_d.id_exe_bubble, if_d.mem_wb_bubble};
  assign ctl_t = {if_t.pc_freeze, if_t.if_id_freeze, if_t.id_exe_freeze, if_t.exe_mem_freeze,
                  if_t.if_id_flush, if_t.id_exe_bubble, if_t.mem_wb_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    fwd_en = 1'b1; id_valid = 1'b0; id_two_src = 1'b0; exe_wb_en = 1'b0;
    exe_mem_r_en = 1'b0; exe_br_taken = 1'b0; mem_wb_en = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
    id_src1 = 5'd0; id_src2 = 5'd0; exe_dest = 5'd0; mem_dest = 5'd0;
  endtask

  task automatic set_lu();
    fwd_en = 1'b1; id_valid = 1'b1; id_src1 = 5'd5;
    exe_dest = 5'd5; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
  endtask

  // Called at posedge+1: check mid-cycle, then advance to the next posedge+1.
  task automatic cyc(input string tag, input int exp, input bit use_t);
    #2;
    chk(tag, use_t ? int'(ctl_t) : int'(ctl_d), exp);
    @(posedge clk); #1;
  endtask

  task automatic vec(input string tag, input int fwd, input int idv, input int s1, input int s2,
                     input int two, input int ed, input int ewb, input int emr,
                     input int md, input int mwb, input int exp);
    fwd_en = 1'(fwd); id_valid = 1'(idv); id_src1 = 5'(s1); id_src2 = 5'(s2);
    id_two_src = 1'(two); exe_dest = 5'(ed); exe_wb_en = 1'(ewb); exe_mem_r_en = 1'(emr);
    mem_dest = 5'(md); mem_wb_en = 1'(mwb);
    cyc(tag, exp, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    idle();
    rst = 1'b0;

    // reset holds controls low even with hazard, stall and branch inputs active
    set_lu(); mem_req = 1'b1; exe_br_taken = 1'b1;
    @(posedge clk); #1;
    chk("rst_ctl_d", int'(ctl_d), C_NONE);
    chk("rst_ctl_t", int'(ctl_t), C_NONE);
    chk("rst_stall", int'(if_d.stall_cnt), 0);
    chk("rst_flush", int'(if_d.flush_cnt), 0);
    chk("rst_err",   int'(if_d.mem_err), 0);
    #1 rst = 1'b1;
    idle();
    @(posedge clk); #1;

    // load-use and source gating
    //   tag          fwd idv s1 s2 two ed ewb emr md mwb exp
    vec("lu_fwd",      1,  1,  5, 0,  0,  5, 1,  1,  0, 0,  C_LU);
    chk("lu_stall1", int'(if_d.stall_cnt), 1);
    vec("alu_fwd",     1,  1,  5, 0,  0,  5, 1,  0,  0, 0,  C_NONE);
    vec("alu_nofwd",   0,  1,  5, 0,  0,  5, 1,  0,  0, 0,  C_LU);
    vec("mem_nofwd",   0,  1,  7, 0,  0,  0, 0,  0,  7, 1,  C_LU);
    vec("mem_fwd",     1,  1,  7, 0,  0,  0, 0,  0,  7, 1,  C_NONE);
    vec("r0_dest",     1,  1,  0, 0,  0,  0, 1,  1,  0, 0,  C_NONE);
    vec("src2_one",    1,  1,  3, 5,  0,  5, 1,  1,  0, 0,  C_NONE);
    vec("src2_two",    1,  1,  3, 5,  1,  5, 1,  1,  0, 0,  C_LU);
    vec("id_invalid",  1,  0,  5, 0,  0,  5, 1,  1,  0, 0,  C_NONE);
    chk("lu_stall4", int'(if_d.stall_cnt), 4);

    // memory wait: 4 frozen cycles, release in the ready cycle
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc("mw_freeze", C_MS, 1'b0);
    mem_ready = 1'b1;
    cyc("mw_ready", C_NONE, 1'b0);
    idle();
    chk("mw_stall", int'(if_d.stall_cnt), 4);

    // branch beats load-use; branch under mem_stall is deferred until RUN
    set_lu(); exe_br_taken = 1'b1;
    cyc("br_over_lu", C_BR, 1'b0);
    idle();
    cyc("br_single", C_NONE, 1'b0);
    chk("br_flush1", int'(if_d.flush_cnt), 1);
    exe_br_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    cyc("br_memstall", C_MS, 1'b0);
    mem_ready = 1'b1;
    cyc("br_in_wait", C_NONE, 1'b0);
    mem_req = 1'b0; mem_ready = 1'b0;
    cyc("br_after", C_BR, 1'b0);
    idle();
    chk("br_flush2", int'(if_d.flush_cnt), 2);
    chk("br_stall5", int'(if_d.stall_cnt), 5);

    // timeout with MEM_TIMEOUT=3: freeze cycles 1-2, release on cycle 3
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    cyc("to_c1", C_MS, 1'b1);
    cyc("to_c2", C_MS, 1'b1);
    #1 chk("to_err_pre", int'(if_t.mem_err), 0);
    cyc("to_c3", C_NONE, 1'b1);
    chk("to_err_set", int'(if_t.mem_err), 1);
    cyc("to_c4", C_MS, 1'b1);
    idle();
    cyc("to_idle", C_NONE, 1'b1);
    chk("to_err_stky", int'(if_t.mem_err), 1);
    chk("to_stall", int'(if_t.stall_cnt), 3);

    // async reset in the middle of MEM_WAIT
    mem_req = 1'b1; mem_ready = 1'b0;
    cyc("ar_c1", C_MS, 1'b0);
    #2 chk("ar_c2", int'(ctl_d), C_MS);
    #1 rst = 1'b0;
    #1;
    chk("ar_ctl_d", int'(ctl_d), C_NONE);
    chk("ar_ctl_t", int'(ctl_t), C_NONE);
    chk("ar_stall", int'(if_d.stall_cnt), 0);
    chk("ar_flush", int'(if_d.flush_cnt), 0);
    chk("ar_err",   int'(if_t.mem_err), 0);
    @(posedge clk); #2;
    rst = 1'b1;
    mem_ready = 1'b1; exe_br_taken = 1'b1;
    #1 chk("ar_run", int'(ctl_d), C_BR);
    @(posedge clk); #1;

    // BR_FLUSH_CYCLES=3 with a memory stall on flush cycle 2
    do_reset();
    exe_br_taken = 1'b1;
    cyc("bf_a", C_BR, 1'b1);
    chk("bf_flush1", int'(if_t.flush_cnt), 1);
    exe_br_taken = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
    cyc("bf_stall", C_MS, 1'b1);
    mem_ready = 1'b1;
    cyc("bf_ready", C_NONE, 1'b1);
    mem_req = 1'b0; mem_ready = 1'b0; exe_br_taken = 1'b1;
    cyc("bf_d", C_BR, 1'b1);
    cyc("bf_e", C_BR, 1'b1);
    exe_br_taken = 1'b0;
    set_lu();
    cyc("bf_run", C_LU, 1'b1);
    idle();
    chk("bf_flushc", int'(if_t.flush_cnt), 1);
    chk("bf_stallc", int'(if_t.stall_cnt), 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
